// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: shares one data-memory port between the CPU and a loader,
//               with round-robin arbitration and a loader-exclusive lock.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader port
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              ldr_lock,
  output logic              locked,
  // Data memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic WIN_CPU = 1'b0;
  localparam logic WIN_LDR = 1'b1;

  state_e            state_q,       state_d;
  logic              last_winner_q, last_winner_d;
  logic              rd_pending_q,  rd_pending_d;
  logic              rd_owner_q,    rd_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q,   cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q,   ldr_rdata_d;

  // Grant decision: the lock only excludes the CPU once the state register has moved.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (state_q == ST_LOCKED) begin
      ldr_gnt = ldr_req;
    end else if (cpu_req && ldr_req) begin
      cpu_gnt = (last_winner_q == WIN_LDR);
      ldr_gnt = (last_winner_q == WIN_CPU);
    end else begin
      cpu_gnt = cpu_req;
      ldr_gnt = ldr_req;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign locked    = (state_q == ST_LOCKED);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (ldr_gnt) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_we;
    end
  end

  // Read data arrives one cycle after the address, so rvalid comes straight
  // from the pending flag and rdata bypasses its holding register that cycle.
  assign cpu_rvalid = rd_pending_q & (rd_owner_q == WIN_CPU);
  assign ldr_rvalid = rd_pending_q & (rd_owner_q == WIN_LDR);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_rdata_q;

  always_comb begin
    state_d       = ldr_lock ? ST_LOCKED : ST_ARB;
    last_winner_d = last_winner_q;
    rd_pending_d  = 1'b0;
    rd_owner_d    = rd_owner_q;
    cpu_rdata_d   = cpu_rdata;
    ldr_rdata_d   = ldr_rdata;
    if (cpu_gnt) begin
      last_winner_d = WIN_CPU;
      rd_pending_d  = ~cpu_we;
      rd_owner_d    = WIN_CPU;
    end else if (ldr_gnt) begin
      last_winner_d = WIN_LDR;
      rd_pending_d  = ~ldr_we;
      rd_owner_d    = WIN_LDR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_ARB;
      last_winner_q <= WIN_LDR;
      rd_pending_q  <= 1'b0;
      rd_owner_q    <= WIN_CPU;
      cpu_rdata_q   <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      rd_pending_q  <= rd_pending_d;
      rd_owner_q    <= rd_owner_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ldr_rdata_q   <= ldr_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
  logic [DATA_W-1:0] cpu_rdata, ldr_rdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic              locked, mem_we;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ldr_lock   (ldr_lock),
    .locked     (locked),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-only memory model with one cycle of read latency.
  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    if (a == 14'h001)      return 32'h0000_0011;
    else if (a == 14'h002) return 32'h0000_0022;
    else                   return 32'hA5A5_0000 | {18'd0, a};
  endfunction

  always @(posedge clock) mem_rdata <= rom(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    ldr_lock = 1'b0;
    idle();
    step();
    step();
    check("rst_locked",    32'(locked),     32'd0);
    check("rst_cpu_rvld",  32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata", cpu_rdata,       32'd0);
    check("rst_ldr_rdata", ldr_rdata,       32'd0);
    check("rst_mem_we",    32'(mem_we),     32'd0);
    reset = 1'b0;

    // Single CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h010;
    #1;
    check("rd1_gnt",   32'(cpu_gnt),   32'd1);
    check("rd1_addr",  32'(mem_addr),  32'h010);
    check("rd1_stall", 32'(cpu_stall), 32'd0);
    step();
    idle();
    #1;
    check("rd1_rvld",  32'(cpu_rvalid), 32'd1);
    check("rd1_rdata", cpu_rdata,       32'hA5A5_0010);
    check("rd1_lrvld", 32'(ldr_rvalid), 32'd0);
    step();
    check("rd1_rvld_off", 32'(cpu_rvalid), 32'd0);
    check("rd1_hold",     cpu_rdata,       32'hA5A5_0010);

    // Round-robin from reset: CPU, LDR, CPU, LDR
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h030; cpu_wdata = 32'h0000_00C0;
    ldr_req = 1; ldr_we = 1; ldr_addr = 14'h031; ldr_wdata = 32'h0000_001D;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_cpu_gnt", 32'(cpu_gnt),   (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ldr_gnt", 32'(ldr_gnt),   (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_stall",   32'(cpu_stall), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_addr",    32'(mem_addr),  (i % 2 == 0) ? 32'h030 : 32'h031);
      check("rr_we",      32'(mem_we),    32'd1);
      step();
    end

    // Lock with both writing; sampling cycle still arbitrates (CPU's turn)
    ldr_lock = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h050; cpu_wdata = 32'h1234_5678;
    ldr_req = 1; ldr_we = 1; ldr_addr = 14'h040; ldr_wdata = 32'hDEAD_BEEF;
    #1;
    check("lk_samp_cgnt",  32'(cpu_gnt), 32'd1);
    check("lk_samp_lock",  32'(locked),  32'd0);
    check("lk_samp_wdata", mem_wdata,    32'h1234_5678);
    step();
    for (int i = 0; i < 2; i++) begin
      check("lk_lgnt",  32'(ldr_gnt),   32'd1);
      check("lk_cgnt",  32'(cpu_gnt),   32'd0);
      check("lk_we",    32'(mem_we),    32'd1);
      check("lk_wdata", mem_wdata,      32'hDEAD_BEEF);
      check("lk_addr",  32'(mem_addr),  32'h040);
      check("lk_stall", 32'(cpu_stall), 32'd1);
      check("lk_lock",  32'(locked),    32'd1);
      step();
    end
    ldr_lock = 0;
    #1;
    check("unlk_still_lock", 32'(locked),  32'd1);
    check("unlk_still_cgnt", 32'(cpu_gnt), 32'd0);
    step();
    check("unlk_lock", 32'(locked),  32'd0);
    check("unlk_cgnt", 32'(cpu_gnt), 32'd1);
    idle();
    step();

    // CPU read in the lock-sampling cycle returns while locked
    ldr_lock = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h020;
    #1;
    check("lkrd_gnt",  32'(cpu_gnt),  32'd1);
    check("lkrd_addr", 32'(mem_addr), 32'h020);
    step();
    check("lkrd_lock",  32'(locked),     32'd1);
    check("lkrd_rvld",  32'(cpu_rvalid), 32'd1);
    check("lkrd_rdata", cpu_rdata,       32'hA5A5_0020);
    check("lkrd_cgnt",  32'(cpu_gnt),    32'd0);
    check("lkrd_we",    32'(mem_we),     32'd0);
    ldr_lock = 0;
    idle();
    step();
    step();

    // Alternating reads, no crossover
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h001;
    step();
    idle();
    ldr_req = 1; ldr_we = 0; ldr_addr = 14'h002;
    #1;
    check("alt_lgnt",   32'(ldr_gnt),    32'd1);
    check("alt_crvld",  32'(cpu_rvalid), 32'd1);
    check("alt_lrvld0", 32'(ldr_rvalid), 32'd0);
    check("alt_crdata", cpu_rdata,       32'h11);
    step();
    idle();
    #1;
    check("alt_lrvld",   32'(ldr_rvalid), 32'd1);
    check("alt_crvld0",  32'(cpu_rvalid), 32'd0);
    check("alt_lrdata",  ldr_rdata,       32'h22);
    check("alt_chold",   cpu_rdata,       32'h11);
    step();
    check("alt_lrvld_off", 32'(ldr_rvalid), 32'd0);
    check("alt_lhold",     ldr_rdata,       32'h22);

    // Reset in the cycle a CPU read is granted
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h010;
    #1;
    check("rrd_gnt",  32'(cpu_gnt),  32'd1);
    check("rrd_addr", 32'(mem_addr), 32'h010);
    step();
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h060; cpu_wdata = 32'h1;
    ldr_req = 1; ldr_we = 1; ldr_addr = 14'h061; ldr_wdata = 32'h2;
    #1;
    check("rrd_rvld",   32'(cpu_rvalid), 32'd0);
    check("rrd_lrvld",  32'(ldr_rvalid), 32'd0);
    check("rrd_crdata", cpu_rdata,       32'd0);
    check("rrd_lrdata", ldr_rdata,       32'd0);
    check("rrd_lock",   32'(locked),     32'd0);
    check("rrd_first",  32'(cpu_gnt),    32'd1);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32, data width of all data buses.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU requests one memory access this cycle.
REQ-006 cpu_we  input  1  CPU access is a write (1) or a read (0).
REQ-007 cpu_addr  input  ADDR_W  CPU word address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_gnt  output  1  CPU access issued to memory this cycle.
REQ-010 cpu_stall  output  1  equals cpu_req & ~cpu_gnt; freezes CPU PC and pipeline.
REQ-011 cpu_rvalid  output  1  CPU read data valid this cycle.
REQ-012 cpu_rdata  output  DATA_W  CPU read data; holds its last value between reads.
REQ-013 ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/ADDR_W/DATA_W  loader (UART program/debug) request port, same meaning as CPU port.
REQ-014 ldr_gnt, ldr_rvalid, ldr_rdata  output  1/1/DATA_W  loader grant, read-valid, read data, same meaning as CPU port.
REQ-015 ldr_lock  input  1  loader requests exclusive ownership of memory.
REQ-016 locked  output  1  arbiter is in LOCKED state.
REQ-017 mem_addr, mem_wdata, mem_we  output  ADDR_W/DATA_W/1  data memory port.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid one cycle after the read address is presented.

Function
REQ-019 FSM states: ARB (shared), LOCKED (loader exclusive); one state register, updated on clock.
REQ-020 ARB->LOCKED when ldr_lock=1 at a clock edge; LOCKED->ARB when ldr_lock=0 at a clock edge.
REQ-021 Grant is combinational in the current cycle from requests, state and a one-bit last_winner register.
REQ-022 In ARB, exactly one requester: that requester is granted.
REQ-023 In ARB, both request: the requester that is not last_winner is granted (round-robin); no requester waits more than 1 cycle.
REQ-024 last_winner updates to the granted requester on every edge where a grant occurred; otherwise it holds.
REQ-025 In LOCKED, cpu_gnt=0 regardless of cpu_req; ldr_req is granted every cycle it is asserted.
REQ-026 The ldr_lock transition takes effect from the cycle after the edge that sampled it; the grant in the sampling cycle follows ARB rules.
REQ-027 mem_addr/mem_wdata/mem_we are driven from the granted port; mem_we = granted port's we; with no grant, mem_we=0 and mem_addr/mem_wdata=0.
REQ-028 mem_we is never asserted for an ungranted port; at most one grant per cycle.
REQ-029 A granted read (we=0) sets a registered rd_owner and rd_pending; the next cycle asserts exactly that owner's rvalid for one cycle and loads mem_rdata into its rdata register.
REQ-030 Granted writes produce no rvalid.
REQ-031 Back-to-back reads from alternating owners return in issue order, one per cycle, each to its own rdata.
REQ-032 A read granted in the last ARB cycle before LOCKED still returns its data and rvalid to the CPU in the first LOCKED cycle.
REQ-033 Addresses are passed unchanged; no wrap, translation or range check.

Reset
REQ-034 On a clock edge with reset=1: state=ARB, last_winner=loader (CPU wins first conflict), rd_pending=0, cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0, locked=0.
REQ-035 A read issued in the cycle reset is sampled is discarded; no rvalid follows.
REQ-036 While reset=1, grants and mem_we follow REQ-022..REQ-027 combinationally, but no register updates occur other than reset values.

Verification
REQ-037 After reset, cpu_req=1 read addr 0x010, ldr idle -> cpu_gnt=1, mem_addr=0x010, next cycle cpu_rvalid=1, cpu_rdata=mem_rdata.
REQ-038 Both request continuously for 4 cycles from reset -> grants CPU, LDR, CPU, LDR; cpu_stall=1 in cycles 2 and 4 only.
REQ-039 ldr_lock=1, cpu_req=1 and ldr_req=1 writes of 0xDEADBEEF held 3 cycles -> after the sampling cycle only ldr_gnt=1, mem_we=1, cpu_stall=1, locked=1; ldr_lock=0 -> CPU granted within 1 cycle.
REQ-040 CPU read at addr 0x020 in the cycle ldr_lock is first sampled -> CPU granted, next cycle cpu_rvalid=1 with data while locked=1.
REQ-041 Alternating reads CPU 0x001, LDR 0x002 with memory returning 0x11/0x22 -> cpu_rdata=0x11, ldr_rdata=0x22, each rvalid exactly one cycle, no crossover.
REQ-042 reset asserted in the cycle a CPU read is granted -> no cpu_rvalid next cycle, all outputs at REQ-034 values.
